instruction_fetch_stage: RTL
============================

Name: instruction_fetch_stage

Overview:
- Upstream neighbour of the program ROM, with the IF/ID boundary register built in.
- Holds the program counter and drives the ROM byte address.
- Captures the returned instruction word together with PC+4 into a registered IF/ID output for decode.
- Supports stall (hold), redirect (branch/jump target load), and flush of the fetched slot.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- TEXT_BASE, 32'h00400000, reset PC and first byte address of program memory.
- MEMORY_DEPTH, 64, program memory depth in words; sets the sequential wrap point.
- NOP_WORD, 32'h00000000, instruction value loaded into the IF/ID slot on flush or reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- Stall_i  input  1  hold PC and IF/ID contents this cycle.
- Redirect_i  input  1  load Target_i into PC and flush the IF/ID slot.
- Target_i  input  DATA_WIDTH  branch/jump byte address.
- Instruction_i  input  DATA_WIDTH  word returned combinationally by program memory for Address_o.
- Address_o  output  DATA_WIDTH  current PC, driven straight from the PC register to program memory.
- Instruction_o  output  DATA_WIDTH  registered IF/ID instruction.
- PC_Plus_4_o  output  DATA_WIDTH  registered PC+4 of the instruction in Instruction_o.
- Valid_o  output  1  IF/ID slot holds a real fetched instruction.
- Fetch_Error_o  output  1  sticky misaligned-redirect flag (see Optional Feature).

Behaviour:
Reset (reset=0, asynchronous, takes effect without a clock edge):
- PC = TEXT_BASE.
- Instruction_o = NOP_WORD, PC_Plus_4_o = 0, Valid_o = 0, Fetch_Error_o = 0.

Timing:
- Address_o equals PC with no combinational path from any input.
- Instruction_i is sampled on the same edge that advances PC.
- Fetch-to-IF/ID latency is one cycle.
- The first valid instruction appears one edge after reset release: Instruction_o = ROM[0], PC_Plus_4_o = TEXT_BASE+4, Valid_o = 1.

Per-edge priority (reset > redirect > stall > advance):
- REDIRECT (Redirect_i=1): PC <= Target_i; Instruction_o <= NOP_WORD; Valid_o <= 0; PC_Plus_4_o <= 0. The word currently on Instruction_i is discarded. Redirect overrides a simultaneous Stall_i.
- STALL (Stall_i=1, Redirect_i=0): PC, Instruction_o, PC_Plus_4_o and Valid_o all hold. Address_o is unchanged, so program memory keeps returning the same word.
- ADVANCE (both 0): Instruction_o <= Instruction_i; PC_Plus_4_o <= PC+4; Valid_o <= 1; PC <= next sequential PC.

Next sequential PC:
- PC+4, except when PC == TEXT_BASE + 4*(MEMORY_DEPTH-1), where it wraps to TEXT_BASE.
- PC_Plus_4_o always reports the arithmetic PC+4, even at the wrap point.
- PC arithmetic is modulo 2^DATA_WIDTH, with no overflow flag.

Redirect targets:
- Targets outside [TEXT_BASE, TEXT_BASE+4*MEMORY_DEPTH) are loaded as given. Range handling belongs to the consumer.

Reset mid-operation:
- Asserting reset during a stall or redirect clears everything immediately to the reset values.
- No pending redirect survives reset.

Optional Feature:
Macro: FETCH_ALIGN_CHECK_EN
- Defined:
  - On REDIRECT with Target_i[1:0] != 0, PC <= {Target_i[DATA_WIDTH-1:2], 2'b00} and Fetch_Error_o <= 1.
  - Fetch_Error_o is sticky and clears only on reset.
  - Aligned targets leave Fetch_Error_o unchanged.
- Not defined:
  - Target_i is loaded unmodified, low bits included.
  - Fetch_Error_o is tied to 0.
  - The port is present in both builds.

Test Plan:
1. Reset release, ROM[0..2] = 0x20080005, 0x20090001, 0x01095020, no stall/redirect -> Address_o = 0x00400000, 0x00400004, 0x00400008 on successive cycles. After edge 1: Instruction_o = 0x20080005, PC_Plus_4_o = 0x00400004, Valid_o = 1.
2. Stall_i = 1 for 3 cycles with PC = 0x00400008 -> Address_o stays 0x00400008 and Instruction_o/PC_Plus_4_o/Valid_o stay frozen. On release, the next edge captures ROM[2] and PC = 0x0040000C.
3. Redirect_i = 1 with Target_i = 0x00400020 while Stall_i = 1 -> PC = 0x00400020 and Valid_o = 0, Instruction_o = 0x00000000. Next edge: Instruction_o = ROM[8], PC_Plus_4_o = 0x00400024.
4. Run sequentially to PC = 0x004000FC (MEMORY_DEPTH = 64) -> next PC = 0x00400000 and PC_Plus_4_o = 0x00400100.
5. With FETCH_ALIGN_CHECK_EN defined: Target_i = 0x00400013 -> PC = 0x00400010, Fetch_Error_o = 1. A subsequent aligned redirect keeps Fetch_Error_o = 1. Without the macro: PC = 0x00400013, Fetch_Error_o = 0.
6. Assert reset between clock edges during a stall at PC = 0x00400030 -> outputs go to reset values immediately with no clock edge. After release, fetch restarts at 0x00400000.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, ROM address, IF/ID boundary register.
// Ports: clk, reset (async low), Stall_i, Redirect_i, Target_i,
//   Instruction_i <- ROM, Address_o -> ROM, IF/ID outputs
//   Instruction_o, PC_Plus_4_o, Valid_o, sticky Fetch_Error_o.
// Option: FETCH_ALIGN_CHECK_EN word-aligns redirect targets and
//   flags misaligned ones on Fetch_Error_o (tied 0 otherwise).
module instruction_fetch_stage #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE = 32'h00400000,
  parameter int MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall_i,
  input  logic                  Redirect_i,
  input  logic [DATA_WIDTH-1:0] Target_i,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0] Instruction_o,
  output logic [DATA_WIDTH-1:0] PC_Plus_4_o,
  output logic                  Valid_o,
  output logic                  Fetch_Error_o
);

  localparam logic [DATA_WIDTH-1:0] FOUR =
    DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] LAST_PC =
    TEXT_BASE + DATA_WIDTH'(4 * (MEMORY_DEPTH - 1));

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] pc_seq;
  logic [DATA_WIDTH-1:0] target;

  assign pc_plus4  = pc + FOUR;
  // Sequential fetch wraps at the last ROM word.
  assign pc_seq    = (pc == LAST_PC) ? TEXT_BASE : pc_plus4;
  assign Address_o = pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign;
  logic fetch_err;

  assign target   = {Target_i[DATA_WIDTH-1:2], 2'b00};
  assign misalign = |Target_i[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_err <= 1'b0;
    end else if (Redirect_i && misalign) begin
      fetch_err <= 1'b1;
    end
  end

  assign Fetch_Error_o = fetch_err;
`else
  assign target        = Target_i;
  assign Fetch_Error_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= TEXT_BASE;
      Instruction_o <= NOP_WORD;
      PC_Plus_4_o   <= '0;
      Valid_o       <= 1'b0;
    end else if (Redirect_i) begin
      pc            <= target;
      Instruction_o <= NOP_WORD;
      PC_Plus_4_o   <= '0;
      Valid_o       <= 1'b0;
    end else if (!Stall_i) begin
      pc            <= pc_seq;
      Instruction_o <= Instruction_i;
      PC_Plus_4_o   <= pc_plus4;
      Valid_o       <= 1'b1;
    end
  end

endmodule
